// File: rtl/fetch_pc_unit_if.sv
// Interface bundling the fetch unit's control inputs, instruction-memory bus and the
// outputs that feed the IF/ID pipeline register.
//   master : the fetch unit side (drives im_addr and the IF/ID outputs)
//   slave  : the pipeline/memory side (drives stall, exc/eret, redirect and im_rdata)
interface fetch_pc_unit_if;
  logic        stall;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_rdata;
  logic [31:0] im_addr;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [4:0]  exc_code_f;
  logic        delay_slot_f;

  modport master (
    input  stall, exc_req, eret_req, epc, redirect_valid, redirect_pc, im_rdata,
    output im_addr, pc_f, instr_f, exc_code_f, delay_slot_f
  );

  modport slave (
    output stall, exc_req, eret_req, epc, redirect_valid, redirect_pc, im_rdata,
    input  im_addr, pc_f, instr_f, exc_code_f, delay_slot_f
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// IF-stage PC unit for the P7 MIPS pipeline.
// Holds the fetch PC, selects the next PC (reset > exception > ERET > stall > redirect >
// sequential), flags AdEL fetch faults (instruction forced to nop) and tracks whether the
// instruction being fetched is in a branch delay slot.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : fetch_pc_unit_if.master -- control inputs, IM bus, IF/ID outputs
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT   = 32'h0000_6ffc
) (
  input  logic             clk,
  input  logic             reset,
  fetch_pc_unit_if.master  bus
);

  logic [31:0] pc_q, pc_d;
  logic        ds_q, ds_d;
  logic        fault;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        is_bj;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      ds_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ds_q <= ds_d;
    end
  end

  // Fault check and predecode depend only on pc_q and im_rdata; nothing here feeds
  // im_addr, so there is no im_rdata -> im_addr loop.
  always_comb begin
    fault  = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);
    instr  = fault ? 32'h0 : bus.im_rdata;
    opcode = instr[31:26];
    funct  = instr[5:0];
    is_bj  = 1'b0;
    case (opcode)
      6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111: is_bj = 1'b1;
      6'b000000: is_bj = (funct == 6'b001000) || (funct == 6'b001001);
      default:   is_bj = 1'b0;
    endcase
  end

  // Exception and ERET win over stall; a redirect seen during stall is dropped because
  // the D stage re-presents it once the stall clears.
  always_comb begin
    pc_d = pc_q + 32'd4;
    ds_d = is_bj;
    if (bus.exc_req) begin
      pc_d = HANDLER_PC;
      ds_d = 1'b0;
    end else if (bus.eret_req) begin
      pc_d = bus.epc;
      ds_d = 1'b0;
    end else if (bus.stall) begin
      pc_d = pc_q;
      ds_d = ds_q;
    end else if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end
  end

  assign bus.im_addr      = pc_q;
  assign bus.pc_f         = pc_q;
  assign bus.instr_f      = instr;
  assign bus.exc_code_f   = fault ? 5'd4 : 5'd0;
  assign bus.delay_slot_f = ds_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic clk;
  logic reset;

  fetch_pc_unit_if bus();

  fetch_pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory, indexed by address bits [9:2].
  logic [31:0] imem [256];
  assign bus.im_rdata = imem[bus.im_addr[9:2]];

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_ds;
  bit          chk_en;

  // Hand-computed expectations for directed cycles.
  bit          lit_en;
  logic [31:0] lit_pc;
  logic        lit_ds;
  logic [4:0]  lit_exc;

  int checks;
  int errors;

  function automatic bit exp_fault(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    if (exp_fault(pc)) return 32'h0;
    return imem[pc[9:2]];
  endfunction

  function automatic bit exp_bj(input logic [31:0] ins);
    int op;
    int fn;
    op = int'(ins >> 26);
    fn = int'(ins & 32'h3f);
    if (op >= 1 && op <= 7) return 1'b1;
    if (op == 0 && (fn == 8 || fn == 9)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Single compare process: DUT vs model every cycle, plus directed literals.
  always @(negedge clk) begin
    if (chk_en) begin
      check32("pc_f", bus.pc_f, m_pc);
      check32("im_addr", bus.im_addr, m_pc);
      check32("instr_f", bus.instr_f, exp_instr(m_pc));
      check32("exc_code_f", {27'b0, bus.exc_code_f}, exp_fault(m_pc) ? 32'd4 : 32'd0);
      check32("delay_slot_f", {31'b0, bus.delay_slot_f}, {31'b0, m_ds});
      if (lit_en) begin
        check32("lit_pc", bus.pc_f, lit_pc);
        check32("lit_ds", {31'b0, bus.delay_slot_f}, {31'b0, lit_ds});
        check32("lit_exc", {27'b0, bus.exc_code_f}, {27'b0, lit_exc});
      end
    end
  end

  task automatic step(input bit r, input bit s, input bit e, input bit er,
                      input logic [31:0] ep, input bit rv, input logic [31:0] rp);
    logic [31:0] cur_instr;
    reset              = r;
    bus.stall          = s;
    bus.exc_req        = e;
    bus.eret_req       = er;
    bus.epc            = ep;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    cur_instr = exp_instr(m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = 32'h3000;
      m_ds = 1'b0;
      chk_en = 1'b1;
    end else if (e) begin
      m_pc = 32'h4180;
      m_ds = 1'b0;
    end else if (er) begin
      m_pc = ep;
      m_ds = 1'b0;
    end else if (!s) begin
      m_ds = exp_bj(cur_instr);
      m_pc = rv ? rp : m_pc + 32'd4;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic step_lit(input bit r, input bit s, input bit e, input bit er,
                          input logic [31:0] ep, input bit rv, input logic [31:0] rp,
                          input logic [31:0] pc, input logic ds, input logic [4:0] exc);
    lit_pc  = pc;
    lit_ds  = ds;
    lit_exc = exc;
    lit_en  = 1'b1;
    step(r, s, e, er, ep, rv, rp);
    lit_en  = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0: a = 32'h3000 + ($urandom_range(0, 32'hfff) << 2) + $urandom_range(1, 3);
      1: a = $urandom_range(0, 32'h2fff);
      2: a = 32'h7000 + $urandom_range(0, 32'hffff);
      default: a = 32'h3000 + ($urandom_range(0, 32'hfff) << 2);
    endcase
    return a;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w = {6'($urandom_range(1, 7)), w[25:0]};
      1: w = {6'b000000, w[25:6], 6'($urandom_range(8, 9))};
      2: w = 32'h0;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    lit_en = 1'b0;
    m_pc   = 32'h0;
    m_ds   = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0] = 32'h1000_0004;  // beq at 0x3000
    imem[7] = 32'h1000_0004;  // beq at 0x301c

    // Reset and free-run, beq at 0x3000 makes 0x3004 a delay slot.
    step_lit(1, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 0);
    step_lit(0, 0, 0, 0, 0, 0, 0, 32'h3004, 1, 0);
    step_lit(0, 0, 0, 0, 0, 1, 32'h3100, 32'h3100, 0, 0);
    step_lit(0, 0, 0, 0, 0, 0, 0, 32'h3104, 0, 0);
    step_lit(0, 0, 0, 0, 0, 0, 0, 32'h3108, 0, 0);
    // Stall with redirect present: PC holds, redirect dropped.
    step_lit(0, 1, 0, 0, 0, 1, 32'h3500, 32'h3108, 0, 0);
    step_lit(0, 1, 0, 0, 0, 1, 32'h3500, 32'h3108, 0, 0);
    step_lit(0, 0, 0, 0, 0, 0, 0, 32'h310c, 0, 0);
    // Exception beats ERET and stall, then ERET returns.
    step_lit(0, 1, 1, 1, 32'h3014, 0, 0, 32'h4180, 0, 0);
    step_lit(0, 0, 0, 1, 32'h3014, 0, 0, 32'h3014, 0, 0);
    // Fault boundaries.
    step_lit(0, 0, 0, 0, 0, 1, 32'h3002, 32'h3002, 0, 4);
    step_lit(0, 0, 0, 0, 0, 1, 32'h7000, 32'h7000, 0, 4);
    step_lit(0, 0, 0, 0, 0, 1, 32'h2ffc, 32'h2ffc, 0, 4);
    step_lit(0, 0, 0, 0, 0, 1, 32'h6ffc, 32'h6ffc, 0, 0);
    step_lit(0, 0, 0, 0, 0, 0, 0, 32'h7000, 0, 4);
    // Reset during stall clears a set delay-slot flag.
    step_lit(0, 0, 0, 0, 0, 1, 32'h301c, 32'h301c, 0, 0);
    step_lit(0, 0, 0, 0, 0, 0, 0, 32'h3020, 1, 0);
    step_lit(0, 1, 0, 0, 0, 0, 0, 32'h3020, 1, 0);
    step_lit(1, 1, 0, 0, 0, 0, 0, 32'h3000, 0, 0);

    // Randomized phase.
    for (int i = 0; i < 256; i++) imem[i] = rand_instr();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 29) == 0,
           rand_addr(),
           $urandom_range(0, 3) == 0,
           rand_addr());
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
